// File: rtl/core_pkg.sv
// Shared definitions for the five-stage core: widths, forwarding select codes,
// control-bundle field offsets and the register-writer match helper.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Layout of the pass-through control bundle carried in id_ctrl/ex_ctrl.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_JUMP       = 6;
    localparam int CTRL_WB_SEL     = 7;

    // A writer only matters when it writes a nonzero register; x0 never matches.
    function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                       input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detection and EX operand-forwarding selects for the ID/EX boundary.
// FORWARD_EN selects between load-use-only stalls with forwarding and full RAW stalls.
module hazard_detect
    import core_pkg::*;
(
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic       ex_flush,
    input  logic       ex_hold,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_reg_write,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_reg_write,
    output logic       bubble,
    output logic       stall_if_id,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       em_we, input logic [4:0] em_rd,
                                           input logic       mw_we, input logic [4:0] mw_rd);
        if (reg_match(em_we, em_rd, src)) return FWD_EXMEM;
        if (reg_match(mw_we, mw_rd, src)) return FWD_MEMWB;
        return FWD_RF;
    endfunction
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_mem_read, ex_rs1, ex_rs2, memwb_rd, memwb_reg_write};
`endif

    logic ex_writer;
    logic ex_hit;

    always_comb begin
        ex_writer = ex_valid && ex_reg_write;
        ex_hit    = reg_match(ex_writer, ex_rd, id_rs1) || reg_match(ex_writer, ex_rd, id_rs2);
`ifdef FORWARD_EN
        bubble = id_valid && ex_mem_read && ex_hit;
        fwd_a  = fwd_sel(ex_rs1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
        fwd_b  = fwd_sel(ex_rs2, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
`else
        // Without forwarding, any producer still in EX or EX/MEM is too young to read.
        bubble = id_valid && (ex_hit
                              || reg_match(exmem_reg_write, exmem_rd, id_rs1)
                              || reg_match(exmem_reg_write, exmem_rd, id_rs2));
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
`endif
        // A flush redirects fetch, so holding IF/ID would only delay the new path.
        stall_if_id = !rst && !ex_flush && (ex_hold || bubble);
        if (rst) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and bubble insertion.
// Define FORWARD_EN to enable operand forwarding (load-use stalls only).
module id_ex_stage
    import core_pkg::*;
#(
    parameter int CTRL_W = core_pkg::CTRL_W,
    parameter int XLEN   = core_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rd1,
    input  logic [XLEN-1:0]   id_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              ex_hold,
    input  logic [4:0]        exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic              memwb_reg_write,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rd1,
    output logic [XLEN-1:0]   ex_rd2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_if_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic [3:0]        ctl_q, ctl_d;
    logic [XLEN-1:0]   pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              bubble;

    hazard_detect u_hazard (
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_flush        (ex_flush),
        .ex_hold         (ex_hold),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .bubble          (bubble),
        .stall_if_id     (stall_if_id),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    always_comb begin
        ctl_d  = {id_valid, id_reg_write, id_mem_read, id_mem_write};
        pc_d   = id_pc;
        rd1_d  = id_rd1;
        rd2_d  = id_rd2;
        imm_d  = id_imm;
        rs1_d  = id_rs1;
        rs2_d  = id_rs2;
        rd_d   = id_rd;
        ctrl_d = id_ctrl;
        // Flush outranks hold; a bubble only applies when EX is free to advance.
        if (ex_flush || (!ex_hold && bubble)) begin
            ctl_d = '0;
        end else if (ex_hold) begin
            ctl_d  = ctl_q;
            pc_d   = pc_q;
            rd1_d  = rd1_q;
            rd2_d  = rd2_q;
            imm_d  = imm_q;
            rs1_d  = rs1_q;
            rs2_d  = rs2_q;
            rd_d   = rd_q;
            ctrl_d = ctrl_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q  <= '0;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else begin
            ctl_q  <= ctl_d;
            pc_q   <= pc_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} = ctl_q;
    assign ex_pc   = pc_q;
    assign ex_rd1  = rd1_q;
    assign ex_rd2  = rd2_q;
    assign ex_imm  = imm_q;
    assign ex_rs1  = rs1_q;
    assign ex_rs2  = rs2_q;
    assign ex_rd   = rd_q;
    assign ex_ctrl = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model of the EX register and
// hazard rules predicts each cycle's outputs; a monitor compares on the falling edge.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [XLEN-1:0]   id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
    logic              ex_flush, ex_hold, exmem_reg_write, memwb_reg_write;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall_if_id;
    logic [XLEN-1:0]   ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [1:0]        fwd_a, fwd_b;

    id_ex_stage #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .stall_if_id(stall_if_id), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct packed {
        logic              rst, id_valid;
        logic [XLEN-1:0]   pc, rd1, rd2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic              reg_write, mem_read, mem_write;
        logic [CTRL_W-1:0] ctrl;
        logic              flush, hold;
        logic [4:0]        exmem_rd;
        logic              exmem_we;
        logic [4:0]        memwb_rd;
        logic              memwb_we;
    } stim_t;

    typedef struct packed {
        logic              valid, reg_write, mem_read, mem_write;
        logic [XLEN-1:0]   pc, rd1, rd2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    typedef struct packed {
        ex_t        ex;
        logic       stall;
        logic [1:0] fa, fb;
    } exp_t;

`ifdef FORWARD_EN
    localparam int LOAD_USE_STALLS = 1;
    localparam int ALU_USE_STALLS  = 0;
`else
    localparam int LOAD_USE_STALLS = 2;
    localparam int ALU_USE_STALLS  = 2;
`endif

    exp_t sb[$];
    ex_t  m;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_stall_last;
    logic stall_seen;
    logic [4:0] p_exmem_rd, p_memwb_rd;
    logic       p_exmem_we, p_memwb_we;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit writes(bit we, bit [4:0] rd, bit [4:0] src);
        return we && (rd != 0) && (rd == src);
    endfunction

    function automatic bit model_hazard(ex_t e, stim_t s);
        bit ex_hit;
        ex_hit = writes(e.valid && e.reg_write, e.rd, s.rs1)
              || writes(e.valid && e.reg_write, e.rd, s.rs2);
`ifdef FORWARD_EN
        return s.id_valid && e.mem_read && ex_hit;
`else
        return s.id_valid && (ex_hit || writes(s.exmem_we, s.exmem_rd, s.rs1)
                                     || writes(s.exmem_we, s.exmem_rd, s.rs2));
`endif
    endfunction

    function automatic logic [1:0] model_fwd(bit [4:0] src, stim_t s);
`ifdef FORWARD_EN
        if (writes(s.exmem_we, s.exmem_rd, src)) return 2'b10;
        if (writes(s.memwb_we, s.memwb_rd, src)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic ex_t model_next(ex_t e, stim_t s);
        ex_t n;
        if (s.rst) return '0;
        if (s.hold && !s.flush) return e;
        n.valid = s.id_valid; n.reg_write = s.reg_write;
        n.mem_read = s.mem_read; n.mem_write = s.mem_write;
        n.pc = s.pc; n.rd1 = s.rd1; n.rd2 = s.rd2; n.imm = s.imm;
        n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd; n.ctrl = s.ctrl;
        if (s.flush || model_hazard(e, s)) begin
            n.valid = 0; n.reg_write = 0; n.mem_read = 0; n.mem_write = 0;
        end
        return n;
    endfunction

    // ---------------- stimulus ----------------
    task automatic apply(input stim_t s);
        rst = s.rst; id_valid = s.id_valid; id_pc = s.pc; id_rd1 = s.rd1; id_rd2 = s.rd2;
        id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_reg_write = s.reg_write; id_mem_read = s.mem_read; id_mem_write = s.mem_write;
        id_ctrl = s.ctrl; ex_flush = s.flush; ex_hold = s.hold;
        exmem_rd = s.exmem_rd; exmem_reg_write = s.exmem_we;
        memwb_rd = s.memwb_rd; memwb_reg_write = s.memwb_we;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #2;
        apply(s);
        if (s.rst) m = '0;
        e.ex    = m;
        e.stall = !s.rst && !s.flush && (s.hold || model_hazard(m, s));
        e.fa    = s.rst ? 2'b00 : model_fwd(m.rs1, s);
        e.fb    = s.rst ? 2'b00 : model_fwd(m.rs2, s);
        sb.push_back(e);
        exp_stall_last = e.stall;
        m = model_next(m, s);
        #1 stall_seen = stall_if_id;
    endtask

    // Drives the younger-stage writers as a real pipeline would, from the model's EX history.
    task automatic pipe_step(input stim_t s);
        ex_t cur;
        s.exmem_rd = p_exmem_rd; s.exmem_we = p_exmem_we;
        s.memwb_rd = p_memwb_rd; s.memwb_we = p_memwb_we;
        cur = m;
        step(s);
        p_memwb_rd = p_exmem_rd; p_memwb_we = p_exmem_we;
        p_exmem_rd = cur.rd;     p_exmem_we = cur.valid && cur.reg_write;
    endtask

    function automatic stim_t instr(bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                                    bit we, bit ld);
        stim_t s = '0;
        s.id_valid = 1; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.reg_write = we; s.mem_read = ld;
        s.pc = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
        s.ctrl = CTRL_W'($urandom);
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        s.id_valid  = ($urandom_range(0, 5) != 0);
        s.mem_write = 1'($urandom);
        s.flush     = ($urandom_range(0, 7) == 0);
        s.hold      = ($urandom_range(0, 5) == 0);
        s.rst       = ($urandom_range(0, 40) == 0);
        s.exmem_rd  = 5'($urandom_range(0, 7)); s.exmem_we = 1'($urandom);
        s.memwb_rd  = 5'($urandom_range(0, 7)); s.memwb_we = 1'($urandom);
        return s;
    endfunction

    task automatic count_stalls(input stim_t consumer, input string name, input int expect_n);
        int stalls = 0;
        for (int k = 0; k < 4; k++) begin
            pipe_step(consumer);
            if (stall_seen === 1'b1) stalls++;
            if (!exp_stall_last) break;
        end
        check(name, 256'(stalls), 256'(expect_n));
    endtask

    task automatic pipe_reset();
        p_exmem_rd = 0; p_exmem_we = 0; p_memwb_rd = 0; p_memwb_we = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ex_ctl", 256'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}),
                      256'({e.ex.valid, e.ex.reg_write, e.ex.mem_read, e.ex.mem_write}));
                check("ex_data", 256'({ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl}),
                      256'({e.ex.pc, e.ex.rd1, e.ex.rd2, e.ex.imm, e.ex.rs1, e.ex.rs2, e.ex.rd, e.ex.ctrl}));
                check("stall_if_id", 256'(stall_if_id), 256'(e.stall));
                check("fwd_a", 256'(fwd_a), 256'(e.fa));
                check("fwd_b", 256'(fwd_b), 256'(e.fb));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    guard;
        m = '0;
        apply('0);
        rst = 1'b1;
        pipe_reset();
        s = '0; s.rst = 1;
        step(s);
        step(s);

        // Reset while EX holds a valid instruction.
        step(instr(1, 2, 3, 1, 0));
        s = '0; s.rst = 1; s.id_valid = 1; s.rs1 = 3; s.hold = 1;
        step(s);
        step('0);

        // Load-use: lw x5 then a consumer of x5.
        pipe_reset();
        pipe_step(instr(2, 0, 5, 1, 1));
        count_stalls(instr(5, 1, 6, 1, 0), "load_use_stalls", LOAD_USE_STALLS);
        pipe_step('0);
        pipe_step('0);

        // ALU producer x7 then a consumer of x7.
        pipe_reset();
        pipe_step(instr(1, 2, 7, 1, 0));
        count_stalls(instr(7, 3, 8, 1, 0), "alu_use_stalls", ALU_USE_STALLS);
        pipe_step('0);
        pipe_step('0);

        // x0 source against an x0 writer never stalls.
        pipe_reset();
        pipe_step(instr(1, 2, 0, 1, 1));
        count_stalls(instr(0, 0, 4, 1, 0), "x0_no_stall", 0);
        pipe_step('0);
        pipe_step('0);

        // Forwarding select priority with both writers targeting x3, then with rd = x0.
        step(instr(4, 3, 9, 1, 0));
        s = '0; s.exmem_rd = 3; s.exmem_we = 1; s.memwb_rd = 3; s.memwb_we = 1;
        step(s);
        s.exmem_rd = 0; s.memwb_rd = 0;
        step(s);
        s.exmem_rd = 0; s.memwb_rd = 3;
        step(s);

        // Flush together with a load-use hazard and hold.
        step(instr(1, 2, 5, 1, 1));
        s = instr(5, 5, 6, 1, 0); s.flush = 1; s.hold = 1;
        step(s);
        step('0);

        // Hold for three cycles with changing ID inputs.
        step(instr(1, 2, 10, 1, 0));
        for (int k = 0; k < 3; k++) begin
            s = rand_stim(); s.rst = 0; s.flush = 0; s.hold = 1;
            step(s);
        end
        step('0);

        for (int k = 0; k < 400; k++) step(rand_stim());
        step('0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        check("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the five-stage core. Captures the operands read from the register file in ID, together with the immediate, PC, register indices and control bits. Detects read-after-write hazards against younger-stage writers and stalls IF/ID, inserting a bubble into EX when it does. Applies branch flushes, and drives the EX operand-forwarding selects.

## Interface
Parameters:
- CTRL_W, 8: width of the pass-through control bundle (ALU op, ALU src, branch/jump, writeback select).
- XLEN, 32: datapath width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_rd1, id_rd2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  hazard-relevant control bits.
- id_ctrl  in  CTRL_W  remaining control bits, passed through unchanged.
- ex_flush  in  1  branch/jump resolved taken in EX.
- ex_hold  in  1  EX cannot advance (multi-cycle unit busy).
- exmem_rd  in  5, exmem_reg_write  in  1  EX/MEM writer.
- memwb_rd  in  5, memwb_reg_write  in  1  MEM/WB writer.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered.
- ex_rs1, ex_rs2, ex_rd  out  5  registered.
- ex_ctrl  out  CTRL_W  registered.
- stall_if_id  out  1  combinational; hold PC and IF/ID this cycle.
- fwd_a, fwd_b  out  2  combinational forwarding selects for EX operands.

## Operation
- Next-state priority: rst > ex_flush > ex_hold > hazard > normal load.
- Normal load: every ex_* field takes its id_* counterpart. ex_valid takes id_valid.
- Bubble (hazard without flush or hold): ex_valid, ex_reg_write, ex_mem_read and ex_mem_write clear to 0. Data fields take the ID values (don't-care).
- ex_flush: same clearing as a bubble. Flush overrides ex_hold. stall_if_id is forced to 0 because the fetch path is being redirected.
- ex_hold: all ex_* registers keep their values. stall_if_id = 1.
- Hazard detection, common rules: only when id_valid. Source index 0 never matches. A writer counts only when its reg_write is 1, its rd is nonzero, and, for the EX writer, ex_valid is 1.
- Load-use hazard: the EX writer has ex_mem_read = 1 and ex_rd equals id_rs1 or id_rs2.
- Forwarding selects, derived from ex_rs1/ex_rs2:
  - 2'b10 when exmem_reg_write, exmem_rd nonzero and exmem_rd equals the source.
  - Otherwise 2'b01 on the same match against the MEM/WB writer.
  - Otherwise 2'b00 (register-file value).
  - EX/MEM has priority over MEM/WB.
- No forwarding is needed for the WB-to-ID distance: the register file writes on the falling edge, so ID reads the new value in the same cycle.

## Timing
- Reset: every ex_* output is 0 immediately on rst assertion. stall_if_id and fwd_* read 0 while rst is high.
- Latency: one cycle, ID to EX.
- Load-use penalty with forwarding: exactly one bubble cycle.
- Flush of a dependent instruction: the flush clears EX, so no stall results. ID is then recomputed the next cycle against an invalid EX.
- Reset mid-stall: reset clears the stall; the pipeline restarts empty.

## Configuration
- FORWARD_EN defined:
  - fwd_a/fwd_b operate as described.
  - Only load-use hazards stall.
- FORWARD_EN undefined:
  - fwd_a/fwd_b are tied to 2'b00.
  - Stall on any RAW hazard against the EX writer (any ex_reg_write) or the EX/MEM writer.
  - Penalty is 2 bubbles at distance 1 and 1 bubble at distance 2.

## Structure
- Shared package core_pkg holds:
  - FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10.
  - CTRL_W and XLEN.
  - The control-bundle field offsets.
- Sub-module hazard_detect: combinational compare logic producing the stall and bubble signals, and fwd_a/fwd_b. The top module holds only the registers and the priority mux.

## Test plan
- Reset asserted mid-run with ex_valid = 1 -> all ex_* = 0 and stall_if_id = 0 without waiting for a clock edge.
- lw x5 in EX, ID instruction with rs1 = x5 -> stall_if_id = 1 for 1 cycle; the next EX is a bubble (ex_valid = 0); then the consumer loads with fwd_a = 2'b01.
- add x3 in EX/MEM and add x3 in MEM/WB, EX instruction rs2 = x3 -> fwd_b = 2'b10; with rd = x0 in both writers -> fwd_b = 2'b00.
- ex_flush = 1 together with a load-use hazard and ex_hold = 1 -> stall_if_id = 0 and next ex_valid = 0.
- ex_hold for 3 cycles -> ex_* unchanged for 3 cycles and stall_if_id = 1 throughout.
- FORWARD_EN undefined, add x7 then a dependent use of x7 -> exactly 2 bubble cycles; ID rs1 = x0 against a writer with rd = x0 -> no stall.
